fetch_predict_unit: RTL and testbench

Parametrised PC/fetch-steering block replacing the fixed "PC+4, resolve in MEM, flush" next-PC logic. Holds the PC, looks up a direct-mapped BTB with saturating counters to predict taken branches and jumps at fetch, and takes branch/jump resolution from the MEM stage. On misprediction it redirects the PC and flushes younger stages; it trains the BTB on every resolution. Sits between the hazard/pipeline-control logic and the IF/ID latch.

---
 rtl/fetch_predict_unit.sv | 160 ++++++++++++++++
 tb/tb_fetch_predict_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_predict_unit
// Description : Program counter and fetch steering. It uses a direct-mapped
//               BTB with saturating counters to predict taken branches and
//               jumps at fetch. Branch/jump resolutions arrive from MEM. On a
//               misprediction it redirects the PC and raises flush. It
//               trains the BTB once per resolution.
//               Optional: define BPRED_STATS_EN to add the branch and
//               mispredict statistics counters (stat_branches and
//               stat_mispredicts).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_predict_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] PC_INIT     = '0,
    parameter int              BTB_ENTRIES = 16,
    parameter int              CTR_BITS    = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            pc_en,
    output logic [XLEN-1:0] imemaddr,
    output logic            pred_taken_if,
    output logic [XLEN-1:0] pred_target_if,
    input  logic            resolve_valid,
    input  logic [XLEN-1:0] resolve_pc,
    input  logic            resolve_taken,
    input  logic [XLEN-1:0] resolve_target,
    input  logic            resolve_pred_taken,
    input  logic [XLEN-1:0] resolve_pred_target,
    output logic            mispredict,
    output logic            flush
`ifdef BPRED_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int                  c_IDX      = $clog2(BTB_ENTRIES);
    localparam int                  c_TAG      = XLEN - c_IDX - 2;
    localparam logic [CTR_BITS-1:0] c_CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] c_CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [XLEN-1:0]     c_FOUR     = XLEN'(4);

    // BTB storage
    logic                r_valid  [BTB_ENTRIES];
    logic [c_TAG-1:0]    r_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]     r_target [BTB_ENTRIES];
    logic [CTR_BITS-1:0] r_ctr    [BTB_ENTRIES];

    logic [XLEN-1:0]  r_pc;
    logic [c_IDX-1:0] w_lk_idx;
    logic [c_TAG-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic [c_IDX-1:0] w_tr_idx;
    logic [c_TAG-1:0] w_tr_tag;
    logic             w_tr_hit;
    logic             w_res_valid;
    logic             w_mispredict;
    logic             w_train;
    logic [XLEN-1:0]  w_next_pc;

    // Fetch-side lookup. It is combinational on the current PC, so it sees
    // the pre-edge BTB contents even when training hits the same entry.
    assign w_lk_idx       = r_pc[c_IDX+1:2];
    assign w_lk_tag       = r_pc[XLEN-1:c_IDX+2];
    assign w_lk_hit       = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign pred_taken_if  = w_lk_hit && r_ctr[w_lk_idx][CTR_BITS-1];
    assign pred_target_if = pred_taken_if ? r_target[w_lk_idx] : '0;
    assign imemaddr       = r_pc;

    // Resolution side. Reset masks resolve_valid so no redirect escapes
    // while RST is high.
    assign w_res_valid  = resolve_valid && !RST;
    assign w_mispredict = w_res_valid &&
                          ((resolve_taken != resolve_pred_taken) ||
                           (resolve_taken && (resolve_target != resolve_pred_target)));
    assign mispredict   = w_mispredict;
    assign flush        = w_mispredict;
    assign w_train      = w_res_valid && pc_en;
    assign w_tr_idx     = resolve_pc[c_IDX+1:2];
    assign w_tr_tag     = resolve_pc[XLEN-1:c_IDX+2];
    assign w_tr_hit     = r_valid[w_tr_idx] && (r_tag[w_tr_idx] == w_tr_tag);

    // Next-PC selection: a redirect wins over a prediction, which wins over
    // the sequential PC.
    always_comb begin
        w_next_pc = r_pc + c_FOUR;
        if (w_mispredict) begin
            w_next_pc = resolve_taken ? resolve_target : (resolve_pc + c_FOUR);
        end else if (pred_taken_if) begin
            w_next_pc = pred_target_if;
        end
    end

    // PC register. A redirect is taken even while stalled so it is not lost.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc <= PC_INIT;
        end else if (w_mispredict || pc_en) begin
            r_pc <= w_next_pc;
        end
    end

    // BTB training. It happens only when the pipeline advances, so a stalled
    // resolution trains exactly once.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= '0;
            end
        end else if (w_train) begin
            if (w_tr_hit) begin
                if (resolve_taken) begin
                    r_target[w_tr_idx] <= resolve_target;
                    if (r_ctr[w_tr_idx] != c_CTR_MAX) begin
                        r_ctr[w_tr_idx] <= r_ctr[w_tr_idx] + CTR_BITS'(1);
                    end
                end else if (r_ctr[w_tr_idx] != '0) begin
                    r_ctr[w_tr_idx] <= r_ctr[w_tr_idx] - CTR_BITS'(1);
                end
            end else if (resolve_taken) begin
                r_valid[w_tr_idx]  <= 1'b1;
                r_tag[w_tr_idx]    <= w_tr_tag;
                r_target[w_tr_idx] <= resolve_target;
                r_ctr[w_tr_idx]    <= c_CTR_WEAK;
            end
        end
    end

`ifdef BPRED_STATS_EN
    logic [31:0] r_stat_br;
    logic [31:0] r_stat_mis;

    // Saturating counts of trained resolutions and of those that mispredicted
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stat_br  <= '0;
            r_stat_mis <= '0;
        end else if (w_train) begin
            if (r_stat_br != 32'hFFFF_FFFF) begin
                r_stat_br <= r_stat_br + 32'd1;
            end
            if (w_mispredict && (r_stat_mis != 32'hFFFF_FFFF)) begin
                r_stat_mis <= r_stat_mis + 32'd1;
            end
        end
    end

    assign stat_branches    = r_stat_br;
    assign stat_mispredicts = r_stat_mis;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_predict_unit
// Description : Testbench for fetch_predict_unit. It runs directed scenarios
//               and then random cycles, and compares against a high-level
//               BTB reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_predict_unit;

    localparam int          c_XLEN = 32;
    localparam int          c_N    = 16;
    localparam int          c_CB   = 2;
    localparam logic [31:0] c_PCI  = 32'h200;

    logic        CLK = 1'b0;
    logic        RST;
    logic        pc_en;
    logic [31:0] imemaddr;
    logic        pred_taken_if;
    logic [31:0] pred_target_if;
    logic        resolve_valid;
    logic [31:0] resolve_pc;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        resolve_pred_taken;
    logic [31:0] resolve_pred_target;
    logic        mispredict;
    logic        flush;
`ifdef BPRED_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    fetch_predict_unit #(
        .XLEN(c_XLEN), .PC_INIT(c_PCI), .BTB_ENTRIES(c_N), .CTR_BITS(c_CB)
    ) u_dut (
        .CLK(CLK), .RST(RST), .pc_en(pc_en),
        .imemaddr(imemaddr), .pred_taken_if(pred_taken_if), .pred_target_if(pred_target_if),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target), .resolve_pred_taken(resolve_pred_taken),
        .resolve_pred_target(resolve_pred_target),
        .mispredict(mispredict), .flush(flush)
`ifdef BPRED_STATS_EN
        , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: each entry remembers which "line" (pc / (4*N)) owns it
    bit          m_valid [c_N];
    longint      m_tag   [c_N];
    logic [31:0] m_tgt   [c_N];
    int          m_ctr   [c_N];
    logic [31:0] m_pc;
    longint      m_br, m_mis;

    function automatic int f_idx(input logic [31:0] pc);
        return int'((longint'(pc) / 4) % c_N);
    endfunction

    function automatic longint f_tag(input logic [31:0] pc);
        return longint'(pc) / (4 * c_N);
    endfunction

    function automatic bit f_pred(input logic [31:0] pc);
        int i = f_idx(pc);
        return m_valid[i] && (m_tag[i] == f_tag(pc)) && (m_ctr[i] >= (1 << (c_CB - 1)));
    endfunction

    function automatic logic [31:0] f_pred_tgt(input logic [31:0] pc);
        return f_pred(pc) ? m_tgt[f_idx(pc)] : 32'h0;
    endfunction

    function automatic bit f_misp();
        if (RST || !resolve_valid) return 1'b0;
        if (resolve_taken != resolve_pred_taken) return 1'b1;
        return resolve_taken && (resolve_target != resolve_pred_target);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < c_N; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 0;
        end
        m_pc  = c_PCI;
        m_br  = 0;
        m_mis = 0;
    endtask

    task automatic model_clock();
        bit          misp;
        logic [31:0] nxt;
        int          i;
        longint      smax = 64'hFFFF_FFFF;
        if (RST) begin
            model_reset();
            return;
        end
        misp = f_misp();
        if (misp) nxt = resolve_taken ? resolve_target : resolve_pc + 32'd4;
        else if (f_pred(m_pc)) nxt = f_pred_tgt(m_pc);
        else nxt = m_pc + 32'd4;
        if (resolve_valid && pc_en) begin
            if (m_br < smax) m_br++;
            if (misp && m_mis < smax) m_mis++;
            i = f_idx(resolve_pc);
            if (m_valid[i] && m_tag[i] == f_tag(resolve_pc)) begin
                if (resolve_taken) begin
                    m_ctr[i] = (m_ctr[i] + 1 > (1 << c_CB) - 1) ? (1 << c_CB) - 1 : m_ctr[i] + 1;
                    m_tgt[i] = resolve_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (resolve_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = f_tag(resolve_pc);
                m_tgt[i]   = resolve_target;
                m_ctr[i]   = 1 << (c_CB - 1);
            end
        end
        if (misp || pc_en) m_pc = nxt;
    endtask

    // Drive one cycle, check the outputs against the model mid-cycle, then clock
    task automatic step(input bit rst, input bit en, input bit rv, input logic [31:0] rpc,
                        input bit tk, input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
        RST = rst; pc_en = en; resolve_valid = rv; resolve_pc = rpc;
        resolve_taken = tk; resolve_target = tgt;
        resolve_pred_taken = ptk; resolve_pred_target = ptgt;
        #2;
        check("imemaddr", imemaddr, m_pc);
        check("pred_taken_if", 32'(pred_taken_if), 32'(f_pred(m_pc)));
        check("pred_target_if", pred_target_if, f_pred_tgt(m_pc));
        check("mispredict", 32'(mispredict), 32'(f_misp()));
        check("flush", 32'(flush), 32'(f_misp()));
`ifdef BPRED_STATS_EN
        check("stat_branches", stat_branches, 32'(m_br));
        check("stat_mispredicts", stat_mispredicts, 32'(m_mis));
`endif
        @(posedge CLK);
        model_clock();
        #1;
    endtask

    task automatic idle(input bit en);
        step(1'b0, en, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Steer fetch to pc using a not-taken resolve of pc-4 that was predicted taken
    task automatic goto_pc(input logic [31:0] pc);
        step(1'b0, 1'b1, 1'b1, pc - 32'd4, 1'b0, 32'h0, 1'b1, 32'h0);
    endtask

    task automatic resolve(input bit en, input logic [31:0] rpc, input bit tk,
                           input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
        step(1'b0, en, 1'b1, rpc, tk, tgt, ptk, ptgt);
    endtask

    logic [31:0] pool [8] = '{32'h40, 32'h44, 32'h80, 32'h84, 32'h100,
                              32'h140, 32'h3C, 32'hFFFF_FFFC};

    initial begin
        RST = 1'b1; pc_en = 1'b0; resolve_valid = 1'b0; resolve_pc = '0;
        resolve_taken = 1'b0; resolve_target = '0; resolve_pred_taken = 1'b0;
        resolve_pred_target = '0;
        @(posedge CLK);
        model_reset();
        #1;
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Reset values and the sequential fetch sequence
        check("rst_pc", imemaddr, 32'h200);
        check("rst_pred", 32'(pred_taken_if), 32'h0);
        check("rst_tgt", pred_target_if, 32'h0);
        check("rst_misp", 32'(mispredict), 32'h0);
        idle(1'b1);
        check("seq_pc1", imemaddr, 32'h204);
        idle(1'b1);
        check("seq_pc2", imemaddr, 32'h208);

        // A taken miss redirects the PC and allocates the entry
        resolve(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        check("redir_pc", imemaddr, 32'h100);
        goto_pc(32'h40);
        check("hit_pred", 32'(pred_taken_if), 32'h1);
        check("hit_tgt", pred_target_if, 32'h100);
        idle(1'b1);
        check("hit_next", imemaddr, 32'h100);

        // Two not-taken resolves weaken the counter until it predicts not-taken
        resolve(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        check("nt_redir", imemaddr, 32'h44);
        resolve(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        goto_pc(32'h40);
        check("nt_pred", 32'(pred_taken_if), 32'h0);

        // Strengthen the counter to saturation; one not-taken still predicts taken
        for (int k = 0; k < 4; k++)
            resolve(1'b1, 32'h40, 1'b1, 32'h100, f_pred(32'h40), f_pred_tgt(32'h40));
        resolve(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        goto_pc(32'h40);
        check("sat_pred", 32'(pred_taken_if), 32'h1);

        // Aliasing: 0x80 shares the index of 0x40 and evicts it
        resolve(1'b1, 32'h80, 1'b1, 32'h180, 1'b0, 32'h0);
        goto_pc(32'h40);
        check("alias_miss", 32'(pred_taken_if), 32'h0);
        goto_pc(32'h80);
        check("alias_hit", 32'(pred_taken_if), 32'h1);
        check("alias_tgt", pred_target_if, 32'h180);

        // Redirect during a stall; training happens once when pc_en rises
        for (int k = 0; k < 3; k++) begin
            resolve(1'b0, 32'h48, 1'b1, 32'h300, 1'b0, 32'h0);
            check("stall_pc", imemaddr, 32'h300);
        end
        resolve(1'b1, 32'h48, 1'b1, 32'h300, 1'b0, 32'h0);
        resolve(1'b1, 32'h48, 1'b0, 32'h0, 1'b1, 32'h300);
        goto_pc(32'h48);
        check("train_once", 32'(pred_taken_if), 32'h0);

        // Reset in the middle of a redirect clears the PC and the BTB
        step(1'b1, 1'b0, 1'b1, 32'h48, 1'b1, 32'h500, 1'b0, 32'h0);
        check("rst_pc2", imemaddr, 32'h200);
        goto_pc(32'h80);
        check("rst_btb", 32'(pred_taken_if), 32'h0);

        // PC+4 wraps around the top of the address space
        goto_pc(32'hFFFF_FFFC);
        idle(1'b1);
        check("wrap_pc", imemaddr, 32'h0);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            logic [31:0] rpc, tgt;
            bit          tk, usem;
            rpc  = ($urandom_range(0, 5) == 0) ? ($urandom & 32'hFFFF_FFFC) : pool[$urandom_range(0, 7)];
            tgt  = pool[$urandom_range(0, 7)];
            tk   = 1'($urandom);
            usem = ($urandom_range(0, 2) != 0);
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom), rpc, tk, tgt,
                 usem ? f_pred(rpc) : 1'($urandom),
                 usem ? f_pred_tgt(rpc) : pool[$urandom_range(0, 7)]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
